// File: rtl/slot_pkg.sv
// Shared constants, state encoding and reel arithmetic for the slot machine game flow.
package slot_pkg;

    // Symbol width and default game parameters
    localparam int unsigned SYM_W           = 4;
    localparam int unsigned NUM_SYMBOLS_DEF = 10;
    localparam int unsigned STRIDE1_DEF     = 1;
    localparam int unsigned STRIDE2_DEF     = 3;
    localparam int unsigned STRIDE3_DEF     = 7;
    localparam int unsigned STRIDE4_DEF     = 9;
    localparam int unsigned AUTO_TICKS_DEF  = 8;

    // Game-flow states
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSpin  = 3'd1,
        StScore = 3'd2,
        StCheck = 3'd3,
        StBroke = 3'd4
    } state_t;

    // One modular step: n + s wrapped into 0..nsym-1. Both operands are below nsym,
    // so a single conditional subtract on a one-bit-wider sum is enough.
    function automatic logic [SYM_W-1:0] reel_step(input logic [SYM_W-1:0] n,
                                                   input logic [SYM_W-1:0] s,
                                                   input int unsigned nsym);
        logic [SYM_W:0] sum;
        logic [SYM_W:0] lim;
        lim = (SYM_W + 1)'(nsym);
        sum = {1'b0, n} + {1'b0, s};
        if (sum >= lim) begin
            sum = sum - lim;
        end
        return sum[SYM_W-1:0];
    endfunction

endpackage

// File: rtl/reel_counter.sv
// Single reel symbol counter: advances by a fixed stride modulo NUM_SYMBOLS when enabled.
module reel_counter
    import slot_pkg::*;
#(
    parameter int unsigned NUM_SYMBOLS = NUM_SYMBOLS_DEF
) (
    input  logic             clk,
    input  logic             btnR,
    input  logic             en,
    input  logic [SYM_W-1:0] stride,
    output logic [SYM_W-1:0] num
);

    logic [SYM_W-1:0] num_d;

    // Next symbol value when the reel is allowed to move
    always_comb begin
        num_d = reel_step(num, stride, NUM_SYMBOLS);
    end

    // Symbol register, cleared by the restart button
    always_ff @(posedge clk or posedge btnR) begin
        if (btnR) begin
            num <= '0;
        end else if (en) begin
            num <= num_d;
        end
    end

endmodule

// File: rtl/reel_sequencer.sv
// Game-flow controller for the four-reel slot machine: starts a spin, stops reels in order
// on button press or auto-timeout, pulses to_score and checks is_broke to end the game.
module reel_sequencer
    import slot_pkg::*;
#(
    parameter int unsigned NUM_SYMBOLS = NUM_SYMBOLS_DEF,
    parameter int unsigned STRIDE1     = STRIDE1_DEF,
    parameter int unsigned STRIDE2     = STRIDE2_DEF,
    parameter int unsigned STRIDE3     = STRIDE3_DEF,
    parameter int unsigned STRIDE4     = STRIDE4_DEF,
    parameter int unsigned AUTO_TICKS  = AUTO_TICKS_DEF
) (
    input  logic             clk,
    input  logic             btnR,
    input  logic             step_tick,
    input  logic             btn_spin,
    input  logic             sw_auto,
    input  logic             is_broke,
    output logic [SYM_W-1:0] num1,
    output logic [SYM_W-1:0] num2,
    output logic [SYM_W-1:0] num3,
    output logic [SYM_W-1:0] num4,
    output logic             stop1,
    output logic             stop2,
    output logic             stop3,
    output logic             stop4,
    output logic             to_score,
    output logic             busy,
    output logic             game_over
);

    localparam int unsigned CNT_W = (AUTO_TICKS > 1) ? $clog2(AUTO_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_TICKS - 1);
    localparam logic [3:0][SYM_W-1:0] STRIDES = {SYM_W'(STRIDE4), SYM_W'(STRIDE3),
                                                 SYM_W'(STRIDE2), SYM_W'(STRIDE1)};

    state_t state_q, state_d;

    logic             btn_q;
    logic             press;
    logic             in_spin;
    logic             auto_hit;
    logic             stop_evt;
    logic [3:0]       stop_q, stop_d;
    logic [3:0]       stopping;
    logic [3:0]       reel_en;
    logic [1:0]       next_reel_q, next_reel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0][SYM_W-1:0] reel_num;

    logic busy_q, busy_d;
    logic to_score_q, to_score_d;
    logic game_over_q, game_over_d;

    // Press detection and stop-event decode; a stopping reel is held out of this tick
    always_comb begin
        press    = btn_spin & ~btn_q;
        in_spin  = (state_q == StSpin);
        auto_hit = sw_auto & step_tick & (cnt_q == CNT_LAST);
        // Press and timeout in the same cycle collapse into a single stop event
        stop_evt = in_spin & (press | auto_hit);
        stopping = stop_evt ? (4'b0001 << next_reel_q) : 4'b0000;
        reel_en  = {4{in_spin & step_tick}} & ~stop_q & ~stopping;
    end

    for (genvar k = 0; k < 4; k++) begin : g_reel
        reel_counter #(
            .NUM_SYMBOLS(NUM_SYMBOLS)
        ) u_reel (
            .clk   (clk),
            .btnR  (btnR),
            .en    (reel_en[k]),
            .stride(STRIDES[k]),
            .num   (reel_num[k])
        );
    end

    // Next values for stop flags, reel pointer and auto-stop tick counter
    always_comb begin
        stop_d      = stop_q;
        next_reel_d = next_reel_q;
        cnt_d       = cnt_q;
        if ((state_q == StIdle) && press) begin
            stop_d      = 4'b0000;
            next_reel_d = 2'd0;
            cnt_d       = '0;
        end else if (in_spin) begin
            if (stop_evt) begin
                stop_d      = stop_q | stopping;
                next_reel_d = next_reel_q + 2'd1;
                cnt_d       = '0;
            end else if (step_tick) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge btnR) begin
        if (btnR) begin
            btn_q       <= 1'b0;
            stop_q      <= 4'b1111;
            next_reel_q <= 2'd0;
            cnt_q       <= '0;
        end else begin
            btn_q       <= btn_spin;
            stop_q      <= stop_d;
            next_reel_q <= next_reel_d;
            cnt_q       <= cnt_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge btnR) begin
        if (btnR) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; presses outside IDLE/SPIN are simply dropped
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (press) state_d = StSpin;
            StSpin:  if (stop_evt && (next_reel_q == 2'd3)) state_d = StScore;
            StScore: state_d = StCheck;
            StCheck: state_d = is_broke ? StBroke : StIdle;
            StBroke: state_d = StBroke;
            default: state_d = StIdle;
        endcase
    end

    // FSM output decode from the upcoming state, so registered outputs track the state
    always_comb begin
        busy_d      = (state_d == StSpin) || (state_d == StScore) || (state_d == StCheck);
        to_score_d  = (state_d == StScore);
        game_over_d = (state_d == StBroke);
    end

    // FSM output registers
    always_ff @(posedge clk or posedge btnR) begin
        if (btnR) begin
            busy_q      <= 1'b0;
            to_score_q  <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            to_score_q  <= to_score_d;
            game_over_q <= game_over_d;
        end
    end

    assign num1      = reel_num[0];
    assign num2      = reel_num[1];
    assign num3      = reel_num[2];
    assign num4      = reel_num[3];
    assign stop1     = stop_q[0];
    assign stop2     = stop_q[1];
    assign stop3     = stop_q[2];
    assign stop4     = stop_q[3];
    assign busy      = busy_q;
    assign to_score  = to_score_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_reel_sequencer.sv
// Self-checking bench for reel_sequencer: vector table plus hand-written corner sequences,
// expectations queued at drive time and compared after each clock edge.
module tb_reel_sequencer;

    typedef struct packed {
        logic [3:0][3:0] n;
        logic [3:0]      stop;
        logic            to_score;
        logic            busy;
        logic            game_over;
    } exp_t;

    typedef struct packed {
        logic btn;
        logic tick;
        logic auto_en;
        logic broke;
        exp_t e;
    } vec_t;

    localparam int STR[4] = '{1, 3, 7, 9};

    logic       clk = 1'b0;
    logic       btnR, step_tick, btn_spin, sw_auto, is_broke;
    logic [3:0] num1, num2, num3, num4;
    logic       stop1, stop2, stop3, stop4, to_score, busy, game_over;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    string nm_q[$];
    vec_t vt[$];

    reel_sequencer dut (
        .clk      (clk),
        .btnR     (btnR),
        .step_tick(step_tick),
        .btn_spin (btn_spin),
        .sw_auto  (sw_auto),
        .is_broke (is_broke),
        .num1     (num1),
        .num2     (num2),
        .num3     (num3),
        .num4     (num4),
        .stop1    (stop1),
        .stop2    (stop2),
        .stop3    (stop3),
        .stop4    (stop4),
        .to_score (to_score),
        .busy     (busy),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int n1, input int n2, input int n3, input int n4,
                                input logic [3:0] st, input logic ts, input logic bz,
                                input logic go);
        exp_t e;
        e.n[0] = 4'(n1);
        e.n[1] = 4'(n2);
        e.n[2] = 4'(n3);
        e.n[3] = 4'(n4);
        e.stop = st;
        e.to_score = ts;
        e.busy = bz;
        e.game_over = go;
        return e;
    endfunction

    function automatic vec_t mkv(input logic b, input logic t, input logic a, input logic br,
                                 input exp_t e);
        vec_t v;
        v.btn = b;
        v.tick = t;
        v.auto_en = a;
        v.broke = br;
        v.e = e;
        return v;
    endfunction

    // Expected outputs after t ticks of a spin where reel k stops on tick period*(k+1)
    function automatic exp_t spin_exp(input int t, input int period);
        exp_t e;
        int stopat, adv;
        e = '0;
        e.busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            stopat = period * (k + 1);
            adv = (t < stopat) ? t : stopat - 1;
            e.n[k] = 4'((adv * STR[k]) % 10);
            e.stop[k] = (t >= stopat);
        end
        e.to_score = (t == 4 * period);
        return e;
    endfunction

    task automatic cmp(input exp_t e, input string nm);
        exp_t a;
        a.n[0] = num1;
        a.n[1] = num2;
        a.n[2] = num3;
        a.n[3] = num4;
        a.stop = {stop4, stop3, stop2, stop1};
        a.to_score = to_score;
        a.busy = busy;
        a.game_over = game_over;
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got n=%0d,%0d,%0d,%0d stop=%b ts=%b busy=%b go=%b; want n=%0d,%0d,%0d,%0d stop=%b ts=%b busy=%b go=%b",
                     nm, a.n[0], a.n[1], a.n[2], a.n[3], a.stop, a.to_score, a.busy,
                     a.game_over, e.n[0], e.n[1], e.n[2], e.n[3], e.stop, e.to_score,
                     e.busy, e.game_over);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge
    task automatic cycle(input logic b, input logic t, input logic a, input logic br,
                         input exp_t e, input string nm);
        @(negedge clk);
        btn_spin = b;
        step_tick = t;
        sw_auto = a;
        is_broke = br;
        sb_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got nothing, want one entry", nm);
        end else begin
            cmp(sb_q.pop_front(), nm_q.pop_front());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        btn_spin = 1'b0;
        step_tick = 1'b0;
        sw_auto = 1'b0;
        is_broke = 1'b0;
        btnR = 1'b1;
        @(negedge clk);
        btnR = 1'b0;
    endtask

    initial begin
        exp_t rst_e;
        rst_e = mk(0, 0, 0, 0, 4'hF, 0, 0, 0);
        btnR = 1'b1;
        step_tick = 1'b0;
        btn_spin = 1'b0;
        sw_auto = 1'b0;
        is_broke = 1'b0;

        // Spin, three ticks, four presses, score, not broke; second game ends broke
        vt.push_back(mkv(1, 0, 0, 0, mk(0, 0, 0, 0, 4'h0, 0, 1, 0)));
        vt.push_back(mkv(0, 1, 0, 0, mk(1, 3, 7, 9, 4'h0, 0, 1, 0)));
        vt.push_back(mkv(0, 1, 0, 0, mk(2, 6, 4, 8, 4'h0, 0, 1, 0)));
        vt.push_back(mkv(0, 1, 0, 0, mk(3, 9, 1, 7, 4'h0, 0, 1, 0)));
        vt.push_back(mkv(0, 0, 0, 0, mk(3, 9, 1, 7, 4'h0, 0, 1, 0)));
        vt.push_back(mkv(1, 0, 0, 0, mk(3, 9, 1, 7, 4'h1, 0, 1, 0)));
        vt.push_back(mkv(0, 0, 0, 0, mk(3, 9, 1, 7, 4'h1, 0, 1, 0)));
        vt.push_back(mkv(1, 0, 0, 0, mk(3, 9, 1, 7, 4'h3, 0, 1, 0)));
        vt.push_back(mkv(0, 0, 0, 0, mk(3, 9, 1, 7, 4'h3, 0, 1, 0)));
        vt.push_back(mkv(1, 0, 0, 0, mk(3, 9, 1, 7, 4'h7, 0, 1, 0)));
        vt.push_back(mkv(0, 0, 0, 0, mk(3, 9, 1, 7, 4'h7, 0, 1, 0)));
        vt.push_back(mkv(1, 0, 0, 0, mk(3, 9, 1, 7, 4'hF, 1, 1, 0)));
        vt.push_back(mkv(0, 0, 0, 0, mk(3, 9, 1, 7, 4'hF, 0, 1, 0)));
        vt.push_back(mkv(0, 0, 0, 0, mk(3, 9, 1, 7, 4'hF, 0, 0, 0)));
        vt.push_back(mkv(1, 0, 0, 0, mk(3, 9, 1, 7, 4'h0, 0, 1, 0)));
        vt.push_back(mkv(0, 1, 0, 0, mk(4, 2, 8, 6, 4'h0, 0, 1, 0)));
        vt.push_back(mkv(1, 0, 0, 0, mk(4, 2, 8, 6, 4'h1, 0, 1, 0)));
        vt.push_back(mkv(0, 0, 0, 0, mk(4, 2, 8, 6, 4'h1, 0, 1, 0)));
        vt.push_back(mkv(1, 0, 0, 0, mk(4, 2, 8, 6, 4'h3, 0, 1, 0)));
        vt.push_back(mkv(0, 0, 0, 0, mk(4, 2, 8, 6, 4'h3, 0, 1, 0)));
        vt.push_back(mkv(1, 0, 0, 0, mk(4, 2, 8, 6, 4'h7, 0, 1, 0)));
        vt.push_back(mkv(0, 0, 0, 0, mk(4, 2, 8, 6, 4'h7, 0, 1, 0)));
        vt.push_back(mkv(1, 0, 0, 0, mk(4, 2, 8, 6, 4'hF, 1, 1, 0)));
        vt.push_back(mkv(1, 0, 0, 0, mk(4, 2, 8, 6, 4'hF, 0, 1, 0)));
        vt.push_back(mkv(0, 0, 0, 1, mk(4, 2, 8, 6, 4'hF, 0, 0, 1)));
        vt.push_back(mkv(1, 0, 0, 0, mk(4, 2, 8, 6, 4'hF, 0, 0, 1)));
        vt.push_back(mkv(0, 1, 0, 0, mk(4, 2, 8, 6, 4'hF, 0, 0, 1)));
        vt.push_back(mkv(1, 0, 0, 0, mk(4, 2, 8, 6, 4'hF, 0, 0, 1)));

        #12;
        cmp(rst_e, "reset_state");
        @(negedge clk);
        btnR = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            cycle(vt[i].btn, vt[i].tick, vt[i].auto_en, vt[i].broke, vt[i].e,
                  $sformatf("vec%0d", i));
        end

        // Auto-stop: reel k stops on tick 8k, to_score follows the 32nd tick
        do_reset();
        cycle(1, 0, 1, 0, mk(0, 0, 0, 0, 4'h0, 0, 1, 0), "auto_start");
        for (int t = 1; t <= 32; t++) begin
            cycle(0, 1, 1, 0, spin_exp(t, 8), $sformatf("auto_t%0d", t));
        end
        cycle(0, 0, 1, 0, mk(7, 5, 1, 9, 4'hF, 0, 1, 0), "auto_check");
        cycle(0, 0, 1, 0, mk(7, 5, 1, 9, 4'hF, 0, 0, 0), "auto_idle");

        // Press and auto-timeout in the same cycle stop exactly one reel
        do_reset();
        cycle(1, 0, 1, 0, mk(0, 0, 0, 0, 4'h0, 0, 1, 0), "both_start");
        for (int t = 1; t <= 7; t++) begin
            cycle(0, 1, 1, 0, spin_exp(t, 1000), $sformatf("both_t%0d", t));
        end
        cycle(1, 1, 1, 0, mk(7, 4, 6, 2, 4'h1, 0, 1, 0), "both_stop");
        cycle(0, 0, 1, 0, mk(7, 4, 6, 2, 4'h1, 0, 1, 0), "both_hold");

        // Press coincident with a tick freezes reel 1 at 5 while the others advance
        do_reset();
        cycle(1, 0, 0, 0, mk(0, 0, 0, 0, 4'h0, 0, 1, 0), "coin_start");
        for (int t = 1; t <= 5; t++) begin
            cycle(0, 1, 0, 0, spin_exp(t, 1000), $sformatf("coin_t%0d", t));
        end
        cycle(1, 1, 0, 0, mk(5, 8, 2, 4, 4'h1, 0, 1, 0), "coin_stop");

        // Asynchronous restart in SPIN
        @(negedge clk);
        btn_spin = 1'b0;
        step_tick = 1'b0;
        #2;
        btnR = 1'b1;
        #1;
        cmp(rst_e, "rst_in_spin");
        @(negedge clk);
        btnR = 1'b0;

        // Asynchronous restart in SCORE suppresses the to_score pulse
        cycle(1, 0, 0, 0, mk(0, 0, 0, 0, 4'h0, 0, 1, 0), "rs_start");
        cycle(0, 0, 0, 0, mk(0, 0, 0, 0, 4'h0, 0, 1, 0), "rs_gap0");
        cycle(1, 0, 0, 0, mk(0, 0, 0, 0, 4'h1, 0, 1, 0), "rs_p1");
        cycle(0, 0, 0, 0, mk(0, 0, 0, 0, 4'h1, 0, 1, 0), "rs_gap1");
        cycle(1, 0, 0, 0, mk(0, 0, 0, 0, 4'h3, 0, 1, 0), "rs_p2");
        cycle(0, 0, 0, 0, mk(0, 0, 0, 0, 4'h3, 0, 1, 0), "rs_gap2");
        cycle(1, 0, 0, 0, mk(0, 0, 0, 0, 4'h7, 0, 1, 0), "rs_p3");
        cycle(0, 0, 0, 0, mk(0, 0, 0, 0, 4'h7, 0, 1, 0), "rs_gap3");
        cycle(1, 0, 0, 0, mk(0, 0, 0, 0, 4'hF, 1, 1, 0), "rs_score");
        #1;
        btn_spin = 1'b0;
        btnR = 1'b1;
        #1;
        cmp(rst_e, "rst_in_score");
        @(negedge clk);
        btnR = 1'b0;
        cycle(0, 0, 0, 0, rst_e, "rst_no_score");
        cycle(1, 0, 0, 0, mk(0, 0, 0, 0, 4'h0, 0, 1, 0), "rst_back_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
